// File: rtl/multicycle_pkg.sv
// multicycle_pkg
//   Shared encodings for the multicycle MIPS control path: opcodes, FSM state
//   enum, ALUOp codes (also used by the ALU control decoder), ALUSrcB and
//   PCSource select values, and the bundled control-output record.
//   Optional feature macro: MULTICYCLE_ADDI_EN (addi opcode becomes legal).
package multicycle_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_SEXT  = 2'b10;
    localparam logic [1:0] SRCB_SHIFT = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
`ifdef MULTICYCLE_ADDI_EN
            OP_ADDI: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_ctrl_decode
//   Combinational state -> control-output table for the multicycle sequencer.
//   Ports:
//     state_i     current FSM state
//     opcode_i    IR[31:26], only looked at in DECODE (illegal detection)
//     mem_ready_i memory handshake; gates IRWrite/PCWrite/instr_done in
//                 FETCH and MEM_WRITE
//     ctrl_o      bundled datapath controls (reset gating is done by the top)
//   Optional feature macro: MULTICYCLE_ADDI_EN (ADDI_EXEC/ADDI_WB rows).
module multicycle_ctrl_decode
    import multicycle_pkg::*;
(
    input  state_e      state_i,
    input  logic [5:0]  opcode_i,
    input  logic        mem_ready_i,
    output ctrl_t       ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                // Branch target is computed here speculatively into ALUOut.
                ctrl_o.alu_src_b = SRCB_SHIFT;
                ctrl_o.alu_op    = ALUOP_ADD;
                if (!op_legal(opcode_i)) begin
                    ctrl_o.illegal_op = 1'b1;
                    ctrl_o.instr_done = 1'b1;
                end
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_SEXT;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.iord       = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            S_EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_RTYPE;
            end
            S_R_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_B;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
`ifdef MULTICYCLE_ADDI_EN
            S_ADDI_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_SEXT;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
`endif
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
//   Main control sequencer for the multicycle MIPS datapath.
//
//   state      | meaning
//   FETCH      | read instruction at PC, PC+4 on mem_ready
//   DECODE     | sample opcode, precompute branch target
//   MEM_ADDR   | base + sign-extended offset for lw/sw
//   MEM_READ   | load access, waits for mem_ready
//   MEM_WB     | load data -> rt
//   MEM_WRITE  | store access, waits for mem_ready
//   EXECUTE    | R-type ALU operation
//   R_WB       | ALUOut -> rd
//   BRANCH     | beq compare, conditional PC load
//   JUMP       | PC <- jump target
//   ADDI_EXEC  | rs + imm (MULTICYCLE_ADDI_EN only)
//   ADDI_WB    | ALUOut -> rt (MULTICYCLE_ADDI_EN only)
//
//   Ports: clk, rst (async active-low), opcode, mem_ready in; PCWrite,
//   PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
//   RegWrite, ALUSrcA, ALUSrcB[1:0], PCSource[1:0], ALUOp[1:0], instr_done,
//   illegal_op out.
//   Optional feature macro: MULTICYCLE_ADDI_EN.
module multicycle_control
    import multicycle_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       instr_done,
    output logic       illegal_op
);

    state_e state_q, state_d;
    // lw/sw choice is captured in DECODE so later opcode changes are ignored.
    logic   is_sw_q, is_sw_d;
    ctrl_t  ctrl;
    ctrl_t  ctrl_gated;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_sw_q <= is_sw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        is_sw_d = is_sw_q;
        case (state_q)
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                is_sw_d = (opcode == OP_SW);
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = is_sw_q ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECUTE:   state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
`ifdef MULTICYCLE_ADDI_EN
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
`endif
            default:     state_d = S_FETCH;
        endcase
    end

    multicycle_ctrl_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    // Outputs are killed combinationally while rst is low so that no memory
    // access or write-back can be issued during reset, even mid-instruction.
    assign ctrl_gated = rst ? ctrl : '0;

    assign PCWrite     = ctrl_gated.pc_write;
    assign PCWriteCond = ctrl_gated.pc_write_cond;
    assign IorD        = ctrl_gated.iord;
    assign MemRead     = ctrl_gated.mem_read;
    assign MemWrite    = ctrl_gated.mem_write;
    assign IRWrite     = ctrl_gated.ir_write;
    assign MemtoReg    = ctrl_gated.mem_to_reg;
    assign RegDst      = ctrl_gated.reg_dst;
    assign RegWrite    = ctrl_gated.reg_write;
    assign ALUSrcA     = ctrl_gated.alu_src_a;
    assign ALUSrcB     = ctrl_gated.alu_src_b;
    assign PCSource    = ctrl_gated.pc_source;
    assign ALUOp       = ctrl_gated.alu_op;
    assign instr_done  = ctrl_gated.instr_done;
    assign illegal_op  = ctrl_gated.illegal_op;

endmodule
